bus_ctrl: RTL
=============

# bus_ctrl

Parametrised bus controller between the CPU and its memory-mapped slaves (RAM, GPU, and later ROM and IO). It replaces the combinational chip-select decode on the board top. It decodes up to N_SLAVES address regions with first-match priority and registers the per-slave read/write strobes. It inserts per-region wait states, honours a slave stretch input, bounds every access with a timeout, and returns ready/error and registered read data to the CPU.

## Interface
Parameters:
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- N_SLAVES, 4, number of decoded regions/slaves
- REGION_BASE, {N_SLAVES{ADDR_W'h0}}, packed base addresses; slot i at [i*ADDR_W +: ADDR_W]
- REGION_MASK, {N_SLAVES{ADDR_W'h0}}, packed masks; slot i matches when (addr & mask_i) == base_i; mask 0 disables slot i
- WAIT_STATES, {N_SLAVES{4'd0}}, packed 4-bit fixed wait states per slot
- TIMEOUT, 255, maximum stretch cycles, range 1..255

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_read  in  1  read request, level
- cpu_write  in  1  write request, level
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle access-complete pulse
- cpu_error  out  1  qualifies cpu_ready: unmapped, timeout, or read&write
- slv_addr  out  ADDR_W  latched address, held for the whole access
- slv_wdata  out  DATA_W  latched write data
- slv_cs_r  out  N_SLAVES  registered one-hot read strobes
- slv_cs_w  out  N_SLAVES  registered one-hot write strobes
- slv_rdata  in  N_SLAVES*DATA_W  packed slave read data
- slv_wait  in  N_SLAVES  slave stretch request, sampled only on the final ACCESS cycle

## Operation
- FSM states: IDLE, ACCESS, STRETCH, DONE, ERROR.
- IDLE: a request is cpu_read|cpu_write. On a request, latch addr, wdata, direction and the decoded slot; load the wait counter with WAIT_STATES[sel].
  - Both read and write asserted -> ERROR.
  - No matching slot -> ERROR.
  - Otherwise -> ACCESS.
- Decode: the lowest-index matching slot wins on overlap. Decode lives in a combinational sub-module.
- ACCESS: slv_cs_r[sel] or slv_cs_w[sel] is high. The counter decrements each cycle. When the counter is 0:
  - slv_wait[sel]=0 -> capture slv_rdata[sel] (reads only), go to DONE.
  - slv_wait[sel]=1 -> go to STRETCH with the timeout counter at 0.
- STRETCH: the strobe stays high and the timeout counter increments.
  - slv_wait[sel]=0 -> capture data, go to DONE.
  - Timeout counter reaches TIMEOUT while wait is still high -> go to ERROR.
- DONE: cpu_ready=1 and cpu_rdata holds the captured data (writes return the last captured value). Strobes are low. Next state is IDLE.
- ERROR: cpu_ready=1, cpu_error=1, cpu_rdata=0, strobes low. Next state is IDLE.
- CPU rule: the CPU drops its request on the edge that ends the ready cycle. A request still high in IDLE starts a new access.
- Request changes during an access are ignored, because all fields are latched.

## Timing
- Reset: state IDLE. cpu_ready, cpu_error, slv_cs_r and slv_cs_w are 0. cpu_rdata, slv_addr and slv_wdata are 0. Counters are 0.
- Reset mid-access: strobes drop on the next edge, with no ready pulse. The pending access is abandoned.
- Mapped access with W=WAIT_STATES[sel] and no stretch:
  - Request seen in cycle 0.
  - Strobe high in cycles 1..W+1 (W+1 cycles).
  - cpu_ready in cycle W+2.
  - IDLE in cycle W+3.
- Stretch of S cycles (S<TIMEOUT) adds S cycles to both the strobe and the ready latency.
- Error paths:
  - Unmapped or read&write: cpu_ready/cpu_error in cycle 1, no strobe.
  - Timeout: error in the cycle after the TIMEOUT-th stretch cycle. The strobe was high W+1+TIMEOUT cycles.
- Back-to-back: the minimum access period is W+3 cycles.
- Strobes are always one-hot or zero. They never change within an access.

## Structure
- Package bus_ctrl_pkg holds:
  - state enum bus_state_t {IDLE, ACCESS, STRETCH, DONE, ERROR};
  - WAIT_W=4;
  - TMO_W=8.
- Sub-module addr_region_match(N_SLAVES, ADDR_W): a combinational first-match decoder with outputs hit and sel index.
- Board mapping for bring-up:
  - slot0 = RAM: base 0x0000, mask 0x8000, W=0.
  - slot1 = GPU: base 0xF800, mask 0xF800, W=1.
  - slots 2-3 disabled.

## Test plan
- RAM read 0x1234, W=0, slave data 0xA5 -> slv_cs_r[0] high for 1 cycle; cpu_ready in cycle 2 with cpu_rdata=0xA5; cpu_error=0.
- GPU write 0xF810, data 0x3C, W=1 -> slv_cs_w[1] high for 2 cycles with slv_wdata=0x3C; ready in cycle 3; no other strobe toggles.
- Unmapped read 0x9000; separately, read&write at 0x0010 -> each gives ready+error in cycle 1, cpu_rdata=0, no strobes.
- GPU read with slv_wait[1] high for 5 cycles, data 0x77 -> strobe high 7 cycles; ready in cycle 8 with 0x77.
- TIMEOUT=4 and slv_wait held high -> error in cycle 7; next request accepted normally.
- Overlapping slots 0/2 both matching 0x0100 -> only slv_cs_r[0] asserts. Reset asserted in cycle 2 of a W=3 access -> strobes 0 next cycle, no ready pulse.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared types and widths for the CPU-side bus controller and its address decoder.
package bus_ctrl_pkg;

  localparam int WAIT_W = 4;
  localparam int TMO_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    STRETCH,
    DONE,
    ERROR
  } bus_state_t;

  // Width of a slot index; a single-slot map still needs a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational first-match region decoder: lowest-index enabled slot whose masked address equals its base wins.
module addr_region_match
  import bus_ctrl_pkg::*;
#(
  parameter int                          N_SLAVES    = 4,
  parameter int                          ADDR_W      = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0]  REGION_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  REGION_MASK = '0,
  parameter int                          SEL_W       = sel_width(N_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  // Scan from the top so the lowest matching index overwrites any higher one.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((REGION_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller: decodes slave regions, drives registered strobes with fixed wait states,
// honours slave stretch with a timeout, and returns ready/error with registered read data.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int                          ADDR_W      = 16,
  parameter int                          DATA_W      = 8,
  parameter int                          N_SLAVES    = 4,
  parameter logic [N_SLAVES*ADDR_W-1:0]  REGION_BASE = {N_SLAVES{{ADDR_W{1'b0}}}},
  parameter logic [N_SLAVES*ADDR_W-1:0]  REGION_MASK = {N_SLAVES{{ADDR_W{1'b0}}}},
  parameter logic [N_SLAVES*WAIT_W-1:0]  WAIT_STATES = {N_SLAVES{4'd0}},
  parameter int                          TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_read,
  input  logic                       cpu_write,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_error,
  output logic [ADDR_W-1:0]          slv_addr,
  output logic [DATA_W-1:0]          slv_wdata,
  output logic [N_SLAVES-1:0]        slv_cs_r,
  output logic [N_SLAVES-1:0]        slv_cs_w,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [N_SLAVES-1:0]        slv_wait
);

  localparam int SEL_W = sel_width(N_SLAVES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  bus_state_t          state;
  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic [N_SLAVES-1:0] dec_onehot;
  logic [SEL_W-1:0]    sel_q;
  logic                is_read_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [N_SLAVES-1:0] cs_r_q;
  logic [N_SLAVES-1:0] cs_w_q;
  logic                req;
  logic                sel_wait;
  logic [DATA_W-1:0]   sel_rdata;

  addr_region_match #(
    .N_SLAVES    (N_SLAVES),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .SEL_W       (SEL_W)
  ) u_match (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign req        = cpu_read | cpu_write;
  assign dec_onehot = N_SLAVES'(1) << dec_sel;
  assign sel_wait   = slv_wait[sel_q];
  assign sel_rdata  = slv_rdata[DATA_W*int'(sel_q) +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      is_read_q <= 1'b0;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_r_q    <= '0;
      cs_w_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            is_read_q <= cpu_read;
            sel_q     <= dec_sel;
            wait_cnt  <= WAIT_STATES[WAIT_W*int'(dec_sel) +: WAIT_W];
            tmo_cnt   <= '0;
            if ((cpu_read && cpu_write) || !dec_hit) begin
              state <= ERROR;
            end else begin
              state <= ACCESS;
              if (cpu_read) cs_r_q <= dec_onehot;
              else          cs_w_q <= dec_onehot;
            end
          end
        end
        // The slave's stretch request only counts once the fixed wait states are spent.
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (!sel_wait) begin
            if (is_read_q) rdata_q <= sel_rdata;
            cs_r_q <= '0;
            cs_w_q <= '0;
            state  <= DONE;
          end else begin
            tmo_cnt <= '0;
            state   <= STRETCH;
          end
        end
        STRETCH: begin
          if (!sel_wait) begin
            if (is_read_q) rdata_q <= sel_rdata;
            cs_r_q <= '0;
            cs_w_q <= '0;
            state  <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            cs_r_q <= '0;
            cs_w_q <= '0;
            state  <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Error completions report zero data without disturbing the last captured read value.
  assign cpu_ready = (state == DONE) || (state == ERROR);
  assign cpu_error = (state == ERROR);
  assign cpu_rdata = (state == ERROR) ? '0 : rdata_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_cs_r  = cs_r_q;
  assign slv_cs_w  = cs_w_q;

endmodule
